// File: rtl/gmii_rx_fcs_check_if.sv
// GMII receive pins plus the FCS-stripped byte stream and per-frame status
// produced by gmii_rx_fcs_check.
interface gmii_rx_fcs_check_if;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;

  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_sof;
  logic        dout_eof;

  logic        stat_valid;
  logic        stat_good;
  logic        stat_crc_err;
  logic        stat_len_err;
  logic        stat_phy_err;
  logic [10:0] stat_len;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  dout, dout_valid, dout_sof, dout_eof,
    input  stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_len
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output dout, dout_valid, dout_sof, dout_eof,
    output stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_len
  );
endinterface

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32 over the frame
// including FCS, forwards the frame without its FCS and reports one status word.
module gmii_rx_fcs_check #(
  parameter int unsigned MIN_PRE = 1,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic             clk,
  input  logic             reset,
  gmii_rx_fcs_check_if.slave bus
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = '1;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [7:0]  PRE_SAT     = '1;
  localparam logic [7:0]  MIN_PRE_C   = 8'(MIN_PRE);
  localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT     = '1;
  localparam logic [2:0]  DLINE_FULL  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP
  } state_t;

  state_t state, state_nxt;

  logic [7:0] rxd;
  logic       dv;
  logic       er;

  assign rxd = bus.gmii_rxd;
  assign dv  = bus.gmii_rx_dv;
  assign er  = bus.gmii_rx_er;

  logic            dv_q;
  logic [7:0]      pre_cnt;
  logic [31:0]     crc;
  logic [10:0]     len_cnt;
  logic            phy_err;
  logic [4:0][7:0] dline;
  logic [2:0]      fill;
  logic            sent_any;

  logic pre_start;
  logic pre_inc;
  logic frame_start;
  logic byte_take;
  logic frame_end;

  logic [7:0]  dout_r;
  logic        dout_valid_r;
  logic        dout_sof_r;
  logic        dout_eof_r;
  logic        stat_valid_r;
  logic        stat_good_r;
  logic        stat_crc_err_r;
  logic        stat_len_err_r;
  logic        stat_phy_err_r;
  logic [10:0] stat_len_r;

  logic        crc_bad;
  logic        len_bad;

  function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pre_start   = 1'b0;
    pre_inc     = 1'b0;
    frame_start = 1'b0;
    byte_take   = 1'b0;
    frame_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        // dv_q resets high, so a frame already running at reset release is ignored
        if (dv && !dv_q) begin
          if (rxd == PRE_BYTE && !er) begin
            state_nxt = ST_PRE;
            pre_start = 1'b1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!dv) begin
          state_nxt = ST_IDLE;
        end else if (er) begin
          state_nxt = ST_DROP;
        end else if (rxd == PRE_BYTE) begin
          pre_inc = 1'b1;
        end else if (rxd == SFD_BYTE && pre_cnt >= MIN_PRE_C) begin
          state_nxt   = ST_DATA;
          frame_start = 1'b1;
        end else begin
          state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (dv) begin
          byte_take = 1'b1;
        end else begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!dv) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    crc_bad = (crc != CRC_RESIDUE);
    // a frame too short to fill the delay line carries no payload at all
    len_bad = (len_cnt < MIN_LEN_C) || (len_cnt > MAX_LEN_C) || (fill != DLINE_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q           <= 1'b1;
      pre_cnt        <= '0;
      crc            <= CRC_INIT;
      len_cnt        <= '0;
      phy_err        <= 1'b0;
      dline          <= '0;
      fill           <= '0;
      sent_any       <= 1'b0;
      dout_r         <= '0;
      dout_valid_r   <= 1'b0;
      dout_sof_r     <= 1'b0;
      dout_eof_r     <= 1'b0;
      stat_valid_r   <= 1'b0;
      stat_good_r    <= 1'b0;
      stat_crc_err_r <= 1'b0;
      stat_len_err_r <= 1'b0;
      stat_phy_err_r <= 1'b0;
      stat_len_r     <= '0;
    end else begin
      dv_q         <= dv;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      dout_sof_r   <= 1'b0;
      dout_eof_r   <= 1'b0;
      stat_valid_r <= 1'b0;

      if (pre_start) begin
        pre_cnt <= 8'd1;
      end else if (pre_inc && pre_cnt != PRE_SAT) begin
        pre_cnt <= pre_cnt + 8'd1;
      end

      if (frame_start) begin
        crc      <= CRC_INIT;
        len_cnt  <= '0;
        phy_err  <= 1'b0;
        fill     <= '0;
        sent_any <= 1'b0;
      end

      if (byte_take) begin
        crc   <= crc_update(crc, rxd);
        dline <= {dline[3:0], rxd};
        if (len_cnt != LEN_SAT) begin
          len_cnt <= len_cnt + 11'd1;
        end
        if (er) begin
          phy_err <= 1'b1;
        end
        // the newest 4 bytes are always held back as potential FCS
        if (fill == DLINE_FULL) begin
          dout_r       <= dline[4];
          dout_valid_r <= 1'b1;
          dout_sof_r   <= !sent_any;
          sent_any     <= 1'b1;
        end else begin
          fill <= fill + 3'd1;
        end
      end

      if (frame_end) begin
        if (fill == DLINE_FULL) begin
          dout_r       <= dline[4];
          dout_valid_r <= 1'b1;
          dout_sof_r   <= !sent_any;
          dout_eof_r   <= 1'b1;
          sent_any     <= 1'b1;
        end
        stat_valid_r   <= 1'b1;
        stat_crc_err_r <= crc_bad;
        stat_len_err_r <= len_bad;
        stat_phy_err_r <= phy_err;
        stat_good_r    <= !(crc_bad || len_bad || phy_err);
        stat_len_r     <= len_cnt;
      end
    end
  end

  assign bus.dout         = dout_r;
  assign bus.dout_valid   = dout_valid_r;
  assign bus.dout_sof     = dout_sof_r;
  assign bus.dout_eof     = dout_eof_r;
  assign bus.stat_valid   = stat_valid_r;
  assign bus.stat_good    = stat_good_r;
  assign bus.stat_crc_err = stat_crc_err_r;
  assign bus.stat_len_err = stat_len_err_r;
  assign bus.stat_phy_err = stat_phy_err_r;
  assign bus.stat_len     = stat_len_r;

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Directed bench for gmii_rx_fcs_check: table of frames plus hand-built
// sequences for bad preamble, 1-cycle inter-frame gap and mid-frame reset.
module tb_gmii_rx_fcs_check;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gmii_rx_fcs_check_if bus ();

  gmii_rx_fcs_check #(
    .MIN_PRE(1),
    .MIN_LEN(64),
    .MAX_LEN(1518)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_d[$];
  bit          rx_sof[$];
  bit          rx_eof[$];
  int          stat_cnt = 0;
  logic        st_good, st_crc, st_lerr, st_phy;
  logic [10:0] st_len;

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      rx_d.push_back(bus.dout);
      rx_sof.push_back(bus.dout_sof);
      rx_eof.push_back(bus.dout_eof);
    end
    if (bus.stat_valid) begin
      stat_cnt <= stat_cnt + 1;
      st_good  <= bus.stat_good;
      st_crc   <= bus.stat_crc_err;
      st_lerr  <= bus.stat_len_err;
      st_phy   <= bus.stat_phy_err;
      st_len   <= bus.stat_len;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string name;
    int    kind;     // 0: payload bytes i with generated FCS, 1: "123456789" with literal FCS
    int    plen;
    int    corrupt;  // payload index whose bit 0 is flipped after the FCS is computed
    int    er_at;    // payload index during which gmii_rx_er is high
    int    nfwd;
    int    len;
    bit    good;
    bit    crc;
    bit    lerr;
    bit    phy;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] frm[$];
  bit         frm_er[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_payload(input int plen, input int corrupt, input int er_at);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    frm_er.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < plen; i++) begin
      b = 8'(i);
      frm.push_back(b);
      frm_er.push_back(i == er_at);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      frm.push_back(c[8*k +: 8]);
      frm_er.push_back(1'b0);
    end
    if (corrupt >= 0) frm[corrupt] = frm[corrupt] ^ 8'h01;
  endtask

  task automatic build_runt();
    logic [7:0] r [13];
    r = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    frm.delete();
    frm_er.delete();
    for (int i = 0; i < 13; i++) begin
      frm.push_back(r[i]);
      frm_er.push_back(1'b0);
    end
  endtask

  task automatic drive(input logic [7:0] d, input bit e);
    bus.gmii_rxd   = d;
    bus.gmii_rx_dv = 1'b1;
    bus.gmii_rx_er = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pre();
    repeat (7) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
  endtask

  task automatic send_body();
    foreach (frm[i]) drive(frm[i], frm_er[i]);
  endtask

  task automatic check_frame(input string tag, input int base, input int sbase,
                             input int nfwd, input int len,
                             input bit good, input bit crc, input bit lerr, input bit phy);
    int n, mism, sofc, eofc, sofi, eofi;
    n = rx_d.size() - base;
    mism = 0; sofc = 0; eofc = 0; sofi = -1; eofi = -1;
    for (int i = 0; i < n; i++) begin
      if (i >= nfwd || rx_d[base+i] !== frm[i]) mism++;
      if (rx_sof[base+i]) begin
        sofc++;
        if (sofi < 0) sofi = i;
      end
      if (rx_eof[base+i]) begin
        eofc++;
        if (eofi < 0) eofi = i;
      end
    end
    chk({tag, ".nbytes"},      n,    nfwd);
    chk({tag, ".data_mism"},   mism, 0);
    chk({tag, ".sof_cnt"},     sofc, (nfwd > 0) ? 1 : 0);
    chk({tag, ".sof_idx"},     sofi, (nfwd > 0) ? 0 : -1);
    chk({tag, ".eof_cnt"},     eofc, (nfwd > 0) ? 1 : 0);
    chk({tag, ".eof_idx"},     eofi, (nfwd > 0) ? nfwd - 1 : -1);
    chk({tag, ".stat_pulses"}, stat_cnt - sbase, 1);
    chk({tag, ".stat_good"},   int'(st_good), int'(good));
    chk({tag, ".stat_crc"},    int'(st_crc),  int'(crc));
    chk({tag, ".stat_lerr"},   int'(st_lerr), int'(lerr));
    chk({tag, ".stat_phy"},    int'(st_phy),  int'(phy));
    chk({tag, ".stat_len"},    int'(st_len),  len);
  endtask

  initial begin
    int base, sbase;

    vecs[0] = '{"good",     0,   60, -1, -1,   60,   64, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"runt",     1,    9, -1, -1,    9,   13, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"crc_bad",  0,   60, 10, -1,   60,   64, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"phy_err",  0,   60, -1, 20,   60,   64, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"len63",    0,   59, -1, -1,   59,   63, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"len5",     0,    1, -1, -1,    1,    5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"len4",     0,    0, -1, -1,    0,    4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"len1518",  0, 1514, -1, -1, 1514, 1518, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"len1519",  0, 1515, -1, -1, 1515, 1519, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dout_valid",   int'(bus.dout_valid),   0);
    chk("rst.dout",         int'(bus.dout),         0);
    chk("rst.stat_valid",   int'(bus.stat_valid),   0);
    chk("rst.stat_good",    int'(bus.stat_good),    0);
    chk("rst.stat_crc_err", int'(bus.stat_crc_err), 0);
    chk("rst.stat_len",     int'(bus.stat_len),     0);
    reset = 1'b1;
    idle(3);

    foreach (vecs[v]) begin
      if (vecs[v].kind == 1) build_runt();
      else build_payload(vecs[v].plen, vecs[v].corrupt, vecs[v].er_at);
      base  = rx_d.size();
      sbase = stat_cnt;
      send_pre();
      send_body();
      idle(3);
      check_frame(vecs[v].name, base, sbase, vecs[v].nfwd, vecs[v].len,
                  vecs[v].good, vecs[v].crc, vecs[v].lerr, vecs[v].phy);
    end

    // malformed preamble: whole burst must be dropped silently
    build_payload(60, -1, -1);
    base  = rx_d.size();
    sbase = stat_cnt;
    drive(8'h55, 1'b0);
    drive(8'h5D, 1'b0);
    drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    send_body();
    idle(1);
    chk("badpre.nbytes",      rx_d.size() - base, 0);
    chk("badpre.stat_pulses", stat_cnt - sbase,   0);
    base  = rx_d.size();
    sbase = stat_cnt;
    send_pre();
    send_body();
    idle(3);
    check_frame("b2b_gap1", base, sbase, 60, 64, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset pulse during payload byte 30, released with dv still high
    build_payload(60, -1, -1);
    send_pre();
    for (int i = 0; i < 30; i++) drive(frm[i], frm_er[i]);
    reset = 1'b0;
    base  = rx_d.size();
    sbase = stat_cnt;
    drive(frm[30], frm_er[30]);
    reset = 1'b1;
    for (int i = 31; i < frm.size(); i++) drive(frm[i], frm_er[i]);
    idle(3);
    chk("midrst.nbytes",      rx_d.size() - base, 0);
    chk("midrst.stat_pulses", stat_cnt - sbase,   0);
    base  = rx_d.size();
    sbase = stat_cnt;
    send_pre();
    send_body();
    idle(3);
    check_frame("after_rst", base, sbase, 60, 64, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
